// File: rtl/rv32i_types.sv
// Shared types for the line memory arbiter: FSM states, client ids and the line data type.
package rv32i_types;

  localparam int LINE_BITS = 256;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    CLIENT_I,
    CLIENT_D
  } arb_client_t;

endpackage

// File: rtl/line_mem_arbiter_rr_select2.sv
// Two-way round-robin pick: a lone requester wins, and on a tie the client
// that was not granted last wins.
module rr_select2
  import rv32i_types::*;
(
  input  logic        i_req,
  input  logic        d_req,
  input  arb_client_t rr_last,
  output logic        grant_valid,
  output arb_client_t grant_client
);

  always_comb begin
    grant_valid  = i_req | d_req;
    grant_client = CLIENT_I;
    if (i_req && d_req) begin
      grant_client = (rr_last == CLIENT_I) ? CLIENT_D : CLIENT_I;
    end else if (d_req) begin
      grant_client = CLIENT_D;
    end
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// Shares one line-granular memory port between the I-cache and D-cache,
// granting whole line transactions round-robin and routing responses back.
module line_mem_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_SIZE = LINE_BITS,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_pmem_address,
  input  logic                 i_pmem_read,
  output logic [LINE_SIZE-1:0] i_pmem_rdata,
  output logic                 i_pmem_resp,
  input  logic [31:0]          d_pmem_address,
  input  logic                 d_pmem_read,
  input  logic                 d_pmem_write,
  input  logic [LINE_SIZE-1:0] d_pmem_wdata,
  output logic [LINE_SIZE-1:0] d_pmem_rdata,
  output logic                 d_pmem_resp,
  output logic [31:0]          mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [LINE_SIZE-1:0] mem_wdata,
  input  logic [LINE_SIZE-1:0] mem_rdata,
  input  logic                 mem_resp,
  output logic [CNT_W-1:0]     i_grant_count,
  output logic [CNT_W-1:0]     d_grant_count
);

  arb_state_t           state_q, state_d;
  arb_client_t          rr_last_q;
  logic                 grant_valid;
  arb_client_t          grant_client;
  logic [31:0]          mem_address_q;
  logic                 mem_read_q, mem_write_q;
  logic [LINE_SIZE-1:0] mem_wdata_q;
  logic [LINE_SIZE-1:0] i_rdata_q, d_rdata_q;
  logic [CNT_W-1:0]     i_cnt_q, d_cnt_q;
  logic                 serve_i_done, serve_d_done, grant_now;

  rr_select2 u_rr_select2 (
    .i_req        (i_pmem_read),
    .d_req        (d_pmem_read | d_pmem_write),
    .rr_last      (rr_last_q),
    .grant_valid  (grant_valid),
    .grant_client (grant_client)
  );

  assign grant_now    = (state_q == IDLE) && grant_valid;
  assign serve_i_done = (state_q == SERVE_I) && mem_resp;
  assign serve_d_done = (state_q == SERVE_D) && mem_resp;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = (grant_client == CLIENT_D) ? SERVE_D : SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is forwarded straight through in the response cycle and held afterwards.
  always_comb begin
    i_pmem_resp  = serve_i_done;
    d_pmem_resp  = serve_d_done;
    i_pmem_rdata = serve_i_done ? mem_rdata : i_rdata_q;
    d_pmem_rdata = serve_d_done ? mem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q     <= CLIENT_I;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_cnt_q       <= '0;
      d_cnt_q       <= '0;
    end else begin
      if (grant_now) begin
        rr_last_q <= grant_client;
        if (grant_client == CLIENT_D) begin
          // A simultaneous read+write from the D-cache is treated as a writeback.
          mem_address_q <= d_pmem_address;
          mem_write_q   <= d_pmem_write;
          mem_read_q    <= ~d_pmem_write;
          mem_wdata_q   <= d_pmem_wdata;
        end else begin
          mem_address_q <= i_pmem_address;
          mem_read_q    <= 1'b1;
          mem_write_q   <= 1'b0;
        end
      end
      if (serve_i_done || serve_d_done) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end
      if (serve_i_done) begin
        i_rdata_q <= mem_rdata;
        i_cnt_q   <= i_cnt_q + CNT_W'(1);
      end
      if (serve_d_done) begin
        d_rdata_q <= mem_rdata;
        d_cnt_q   <= d_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_address   = mem_address_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_wdata     = mem_wdata_q;
  assign i_grant_count = i_cnt_q;
  assign d_grant_count = d_cnt_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Randomized self-checking bench for line_mem_arbiter against a transaction-level reference model.
module tb_line_mem_arbiter;
  import rv32i_types::*;

  localparam int LS = 256;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   i_pmem_address;
  logic          i_pmem_read;
  logic [LS-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic [31:0]   d_pmem_address;
  logic          d_pmem_read, d_pmem_write;
  logic [LS-1:0] d_pmem_wdata, d_pmem_rdata;
  logic          d_pmem_resp;
  logic [31:0]   mem_address;
  logic          mem_read, mem_write;
  logic [LS-1:0] mem_wdata, mem_rdata;
  logic          mem_resp;
  logic [CW-1:0] i_grant_count, d_grant_count;

  line_mem_arbiter #(.LINE_SIZE(LS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [LS-1:0] got, input logic [LS-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // stimulus knobs and bench-side cache/memory state
  bit    rnd_en = 0, rehold = 0, stray_en = 0, force_stray = 0, fill_en = 0;
  int    lat_fixed = -1;
  line_t fill_val = '0;
  bit    i_seen = 0, d_seen = 0, mem_act = 0;
  int    mem_wait = 0;

  // reference model: one outstanding line transaction, round-robin on ties
  bit          m_busy = 0, m_wr = 0;
  arb_client_t m_cl = CLIENT_I, m_rr = CLIENT_I;
  logic [31:0] m_addr = '0;
  line_t       m_wdata = '0, m_i_last = '0, m_d_last = '0;
  int unsigned m_cnt_i = 0, m_cnt_d = 0;
  arb_client_t resp_log[$];

  function automatic line_t rand_line();
    line_t r;
    for (int k = 0; k < LS / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    bit          i_drop, d_drop, ri, rd, exp_ir, exp_dr;
    arb_client_t win;
    i_drop = i_seen;
    d_drop = d_seen;
    if (i_seen) begin i_pmem_read = 0; i_seen = 0; end
    if (d_seen) begin d_pmem_read = 0; d_pmem_write = 0; d_seen = 0; end
    if (rnd_en) begin
      if (!i_pmem_read && !i_drop && $urandom_range(0, 3) == 0) begin
        i_pmem_read = 1;
        i_pmem_address = $urandom & 32'hFFFF_FFE0;
      end else if (i_pmem_read && $urandom_range(0, 31) == 0) i_pmem_read = 0;
      if (!(d_pmem_read || d_pmem_write) && !d_drop && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) d_pmem_write = 1; else d_pmem_read = 1;
        d_pmem_address = $urandom & 32'hFFFF_FFE0;
        d_pmem_wdata = rand_line();
      end else if ((d_pmem_read || d_pmem_write) && $urandom_range(0, 31) == 0) begin
        d_pmem_read = 0; d_pmem_write = 0;
      end
    end
    if (rehold) begin
      if (!i_pmem_read && !i_drop) begin
        i_pmem_read = 1; i_pmem_address = $urandom & 32'hFFFF_FFE0;
      end
      if (!d_pmem_read && !d_drop) begin
        d_pmem_read = 1; d_pmem_address = $urandom & 32'hFFFF_FFE0;
      end
    end
    mem_rdata = fill_en ? fill_val : rand_line();
    if (mem_read || mem_write) begin
      if (!mem_act) begin
        mem_act = 1;
        mem_wait = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
      end
      if (mem_wait == 0) begin mem_resp = 1; mem_act = 0; end
      else begin mem_resp = 0; mem_wait--; end
    end else begin
      mem_resp = force_stray || (stray_en && $urandom_range(0, 5) == 0);
    end
    #1;
    assert (!(d_pmem_read && d_pmem_write)) else $error("FAIL d_read_and_write_together");
    chk("mem_read", LS'(mem_read), LS'(m_busy && !m_wr));
    chk("mem_write", LS'(mem_write), LS'(m_busy && m_wr));
    if (m_busy) begin
      chk("mem_address", LS'(mem_address), LS'(m_addr));
      if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    end
    exp_ir = m_busy && (m_cl == CLIENT_I) && mem_resp;
    exp_dr = m_busy && (m_cl == CLIENT_D) && mem_resp;
    chk("i_resp", LS'(i_pmem_resp), LS'(exp_ir));
    chk("d_resp", LS'(d_pmem_resp), LS'(exp_dr));
    chk("i_rdata", i_pmem_rdata, exp_ir ? mem_rdata : m_i_last);
    chk("d_rdata", d_pmem_rdata, exp_dr ? mem_rdata : m_d_last);
    chk("i_count", LS'(i_grant_count), LS'(m_cnt_i));
    chk("d_count", LS'(d_grant_count), LS'(m_cnt_d));
    if (i_pmem_resp) begin i_seen = 1; resp_log.push_back(CLIENT_I); end
    if (d_pmem_resp) begin d_seen = 1; resp_log.push_back(CLIENT_D); end
    if (rst) begin
      m_busy = 0; m_rr = CLIENT_I; m_cnt_i = 0; m_cnt_d = 0;
      m_i_last = '0; m_d_last = '0; mem_act = 0; i_seen = 0; d_seen = 0;
    end else if (m_busy) begin
      if (mem_resp) begin
        m_busy = 0;
        if (m_cl == CLIENT_I) begin m_cnt_i++; m_i_last = mem_rdata; end
        else begin m_cnt_d++; m_d_last = mem_rdata; end
      end
    end else begin
      ri = i_pmem_read;
      rd = d_pmem_read || d_pmem_write;
      if (ri || rd) begin
        if (ri && rd) win = (m_rr == CLIENT_I) ? CLIENT_D : CLIENT_I;
        else win = rd ? CLIENT_D : CLIENT_I;
        m_rr = win; m_cl = win; m_busy = 1;
        if (win == CLIENT_D) begin
          m_addr = d_pmem_address; m_wr = d_pmem_write; m_wdata = d_pmem_wdata;
        end else begin
          m_addr = i_pmem_address; m_wr = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rnd_en = 0; rehold = 0; stray_en = 0;
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic wait_resp(input string tag, input arb_client_t c, input int max);
    int n = 0;
    bit got = 0;
    while (!got && n < max) begin
      step();
      n++;
      got = (c == CLIENT_I) ? i_seen : d_seen;
    end
    chk({tag, "_done"}, LS'(got), LS'(1));
  endtask

  initial begin
    rst = 1; i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
    i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // reset state, idle cycles, stray response in IDLE
    do_reset();
    repeat (5) step();
    force_stray = 1; step(); force_stray = 0;
    chk("t1_i_count", LS'(i_grant_count), LS'(0));

    // single I read with fixed 3-cycle memory latency
    lat_fixed = 3; fill_en = 1; fill_val = {32{8'hA5}};
    i_pmem_address = 32'h0000_1020; i_pmem_read = 1;
    step();
    chk("t2_mem_addr", LS'(mem_address), LS'(32'h0000_1020));
    chk("t2_mem_read", LS'(mem_read), LS'(1));
    wait_resp("t2_i", CLIENT_I, 20);
    chk("t2_rdata", i_pmem_rdata, fill_val);
    step();
    chk("t2_i_count", LS'(i_grant_count), LS'(1));
    fill_en = 0; lat_fixed = -1;

    // simultaneous reads after reset: D first
    do_reset();
    resp_log.delete();
    i_pmem_address = 32'h0000_2000; i_pmem_read = 1;
    d_pmem_address = 32'h0000_3000; d_pmem_read = 1;
    wait_resp("t3_d", CLIENT_D, 20);
    wait_resp("t3_i", CLIENT_I, 20);
    if (resp_log.size() > 0) chk("t3_first", LS'(resp_log[0]), LS'(CLIENT_D));
    else chk("t3_log_size", LS'(resp_log.size()), LS'(2));
    step();
    chk("t3_counts", LS'({i_grant_count, d_grant_count}), LS'({32'd1, 32'd1}));

    // D writeback
    do_reset();
    d_pmem_address = 32'h8000_0040; d_pmem_wdata = {8{32'h1234_5678}}; d_pmem_write = 1;
    step();
    chk("t4_mem_write", LS'(mem_write), LS'(1));
    chk("t4_mem_read", LS'(mem_read), LS'(0));
    chk("t4_wdata", mem_wdata, {8{32'h1234_5678}});
    wait_resp("t4_d", CLIENT_D, 20);

    // back-to-back contention: strict alternation D,I,D,I...
    do_reset();
    resp_log.delete();
    rehold = 1;
    for (int n = 0; n < 200 && resp_log.size() < 8; n++) step();
    rehold = 0;
    chk("t5_log_size", LS'(resp_log.size()), LS'(8));
    for (int k = 0; k < resp_log.size() && k < 8; k++)
      chk($sformatf("t5_order%0d", k), LS'(resp_log[k]), LS'((k % 2 == 0) ? CLIENT_D : CLIENT_I));
    chk("t5_counts", LS'({i_grant_count, d_grant_count}), LS'({32'd4, 32'd4}));

    // reset in the middle of an I transaction
    do_reset();
    lat_fixed = 6;
    i_pmem_address = 32'h0000_4000; i_pmem_read = 1;
    repeat (3) step();
    i_pmem_read = 0; rst = 1;
    step();
    rst = 0;
    chk("t6_mem_read", LS'(mem_read), LS'(0));
    force_stray = 1; step(); force_stray = 0;
    lat_fixed = -1;
    i_pmem_address = 32'h0000_5020; i_pmem_read = 1;
    wait_resp("t6_i", CLIENT_I, 20);
    step();
    chk("t6_i_count", LS'(i_grant_count), LS'(1));

    // long randomized run with drops and stray responses
    do_reset();
    rnd_en = 1; stray_en = 1;
    repeat (3000) step();
    rnd_en = 0; stray_en = 0;
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shares one line-granular physical memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches' pmem_* ports and the burst/line adapter to DRAM.
- Grants one whole line transaction at a time using a round-robin policy.
- Routes the response and read data back to the granted cache only.

Parameters:
- LINE_SIZE, 256, line width in bits for all rdata/wdata buses.
- CNT_W, 32, width of the per-client grant counters (performance only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_pmem_address  in  32  I-cache line address (bits [4:0] are zero)
- i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
- i_pmem_rdata  out  LINE_SIZE  line data to I-cache
- i_pmem_resp  out  1  one-cycle completion to I-cache
- d_pmem_address  in  32  D-cache line address
- d_pmem_read  in  1  D-cache line read request, held until d_pmem_resp
- d_pmem_write  in  1  D-cache line writeback request, held until d_pmem_resp
- d_pmem_wdata  in  LINE_SIZE  writeback data
- d_pmem_rdata  out  LINE_SIZE  line data to D-cache
- d_pmem_resp  out  1  one-cycle completion to D-cache
- mem_address  out  32  registered line address to memory
- mem_read  out  1  registered read strobe, held until mem_resp
- mem_write  out  1  registered write strobe, held until mem_resp
- mem_wdata  out  LINE_SIZE  registered write data
- mem_rdata  in  LINE_SIZE  line read data, valid with mem_resp
- mem_resp  in  1  one-cycle completion from memory
- i_grant_count  out  CNT_W  number of I-cache transactions completed
- d_grant_count  out  CNT_W  number of D-cache transactions completed

Behaviour:
- Reset: state IDLE; rr_last = I, so D wins the first tie. mem_read, mem_write, mem_address, mem_wdata, both resp outputs, both rdata outputs and both counters are 0.
- States:
  - IDLE: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
    - Only one request present: grant that client.
    - Both present: grant the client that is not rr_last.
    - On grant: latch address, wdata and read/write kind into the mem_* registers; set rr_last to the granted client; go to SERVE_I or SERVE_D.
    - No request: stay in IDLE.
  - SERVE_I / SERVE_D: mem_* outputs stay constant.
    - On mem_resp: pass mem_rdata and mem_resp combinationally to the granted client's rdata/resp in the same cycle. Deassert mem_read/mem_write at the next edge, increment that client's counter, and go to IDLE.
    - The other client's resp stays 0 and its rdata holds its last value.
- Latency: request sampled in IDLE at cycle N. mem strobe is high from N+1. Client resp arrives in the same cycle as mem_resp (cycle M). State is IDLE at M+1; the earliest next grant is at M+1, with its strobe at M+2. Minimum gap between transactions is one idle cycle.
- D read and write both high in the same cycle: protocol violation; the write is serviced. The bench flags this with an assertion.
- Client drops its request mid-transaction: the arbiter still completes the memory transaction. The resp is still pulsed to that client and the data is discarded by it; no abort.
- A request that arrives while another client is being served waits; the waiting client must hold its request.
- Request held through its own resp cycle: it is treated as a new request in IDLE. This cannot occur with the cache protocol, because each cache drops its strobe the cycle after resp.
- mem_resp while in IDLE: ignored; no client resp.
- rst mid-transaction: returns to IDLE and drops strobes immediately at the edge. The memory side is reset in the same cycle; any later stale mem_resp is ignored under the IDLE rule.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- Shared package rv32i_types:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}.
  - arb_client_t enum {CLIENT_I, CLIENT_D}.
  - line_t type parameterised on LINE_SIZE.
- One natural sub-module: rr_select2, a combinational two-way round-robin pick from (i_req, d_req, rr_last) to (grant_valid, grant_client). The FSM, latching and counters stay in line_mem_arbiter.

Test Plan:
- Reset, then idle 5 cycles -> all mem strobes 0, both resp 0, counters 0; a mem_resp pulse in IDLE produces no client resp.
- i_pmem_read=1, addr 0x0000_1020; memory responds 3 cycles after mem_read rises with rdata 0xA5.. -> mem_address=0x0000_1020 and mem_read=1 from cycle N+1. i_pmem_resp pulses for exactly one cycle with rdata 0xA5..; d_pmem_resp stays 0; i_grant_count=1.
- I and D reads asserted in the same cycle after reset -> D is granted first (rr_last=I). I's strobe appears 2 cycles after D's resp. Counters end at I=1, D=1.
- D writeback addr 0x8000_0040, wdata 0x1234.. -> mem_write=1, mem_read=0, mem_wdata matches; write completes on mem_resp and d_pmem_resp pulses.
- Both clients request back-to-back for 8 transactions -> grants strictly alternate D,I,D,I...; no transaction is lost; final counts are 4/4.
- rst asserted 2 cycles into an I transaction -> next cycle is IDLE with mem_read=0. A later stray mem_resp produces no client resp, and the following fresh I request is served normally.
